// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clock divider and its output monitor.
package clk_div_pkg;

  // Monitor FSM states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    MEASURE = 3'd2,
    LOCKED  = 3'd3,
    FAULT   = 3'd4
  } mon_state_t;

  localparam int FAULT_CNT_W = 8;

  // Saturating increment for the fault entry counter.
  function automatic logic [FAULT_CNT_W-1:0] fault_cnt_inc(input logic [FAULT_CNT_W-1:0] v);
    if (v == {FAULT_CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + FAULT_CNT_W'(1);
    end
  endfunction

endpackage

// File: rtl/clk_edge_detect.sv
// Rising-edge detector for a divided clock already sampled in the clk_in domain.
// Reusable by any consumer of a divided clock.
module clk_edge_detect (
  input  logic clk_in,
  input  logic reset,
  input  logic mon_clk,
  output logic mon_rise
);

  logic mon_q;

  // Hold the previous sample of mon_clk for edge comparison.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      mon_q <= 1'b0;
    end else begin
      mon_q <= mon_clk;
    end
  end

  assign mon_rise = mon_clk & ~mon_q;

endmodule

// File: rtl/clk_out_monitor.sv
// Divided-clock monitor: measures each mon_clk period in clk_in cycles,
// declares lock after LOCK_COUNT consecutive good periods and raises a
// sticky fault on an out-of-tolerance period or a stuck clock.
module clk_out_monitor
  import clk_div_pkg::*;
#(
  parameter int PERIOD     = 10,
  parameter int TOL        = 1,
  parameter int LOCK_COUNT = 4,
  parameter int CNT_W      = 8
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   fault_clr,
  input  logic                   mon_clk,
  output logic                   edge_tick,
  output logic [CNT_W-1:0]       period,
  output logic                   locked,
  output logic                   fault,
  output logic [FAULT_CNT_W-1:0] fault_count
);

  localparam int LO_INT   = (PERIOD - TOL < 1) ? 1 : (PERIOD - TOL);
  localparam int SYNC_INT = (2 * (PERIOD + TOL) > (2 ** CNT_W) - 1) ? (2 ** CNT_W) - 1
                                                                     : 2 * (PERIOD + TOL);
  localparam int GOOD_W   = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0]  LO_LIM   = CNT_W'(LO_INT);
  localparam logic [CNT_W-1:0]  HI_LIM   = CNT_W'(PERIOD + TOL);
  localparam logic [CNT_W-1:0]  SYNC_LIM = CNT_W'(SYNC_INT);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [GOOD_W-1:0] LOCK_LIM = GOOD_W'(LOCK_COUNT);

  mon_state_t        state_r;
  mon_state_t        state_nxt_s;
  logic [CNT_W-1:0]  cnt;
  logic [GOOD_W-1:0] good_cnt;
  logic [GOOD_W-1:0] good_cnt_nxt_s;
  logic              edge_s;
  logic [CNT_W-1:0]  meas_s;
  logic              good_s;
  logic              timeout_s;
  logic              sync_to_s;
  logic              counting_s;

  clk_edge_detect u_edge (
    .clk_in   (clk_in),
    .reset    (reset),
    .mon_clk  (mon_clk),
    .mon_rise (edge_s)
  );

  // The edge cycle itself is the last cycle of the period, hence the +1.
  assign meas_s     = cnt + CNT_W'(1);
  assign good_s     = (meas_s >= LO_LIM) && (meas_s <= HI_LIM);
  assign timeout_s  = (cnt == HI_LIM) && !edge_s;
  assign sync_to_s  = (cnt >= SYNC_LIM) && !edge_s;
  assign counting_s = enable && (state_r == SYNC || state_r == MEASURE || state_r == LOCKED);

  // Next-state and good-period run length; enable low overrides everything.
  always_comb begin
    state_nxt_s    = state_r;
    good_cnt_nxt_s = good_cnt;
    if (!enable) begin
      state_nxt_s    = IDLE;
      good_cnt_nxt_s = '0;
    end else begin
      case (state_r)
        IDLE: begin
          state_nxt_s    = SYNC;
          good_cnt_nxt_s = '0;
        end
        SYNC: begin
          if (edge_s) begin
            state_nxt_s    = MEASURE;
            good_cnt_nxt_s = '0;
          end else if (sync_to_s) begin
            state_nxt_s = FAULT;
          end else begin
            state_nxt_s = SYNC;
          end
        end
        MEASURE: begin
          if (edge_s) begin
            if (good_s) begin
              good_cnt_nxt_s = good_cnt + GOOD_W'(1);
              if (good_cnt_nxt_s >= LOCK_LIM) begin
                state_nxt_s = LOCKED;
              end else begin
                state_nxt_s = MEASURE;
              end
            end else begin
              good_cnt_nxt_s = '0;
            end
          end else if (timeout_s) begin
            state_nxt_s = FAULT;
          end else begin
            state_nxt_s = MEASURE;
          end
        end
        LOCKED: begin
          if (edge_s) begin
            if (!good_s) begin
              state_nxt_s = FAULT;
            end else begin
              state_nxt_s = LOCKED;
            end
          end else if (timeout_s) begin
            state_nxt_s = FAULT;
          end else begin
            state_nxt_s = LOCKED;
          end
        end
        FAULT: begin
          if (fault_clr) begin
            state_nxt_s    = SYNC;
            good_cnt_nxt_s = '0;
          end else begin
            state_nxt_s = FAULT;
          end
        end
        default: begin
          state_nxt_s    = IDLE;
          good_cnt_nxt_s = '0;
        end
      endcase
    end
  end

  // Period counter: restarts on each edge, held at zero while not measuring.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      period <= '0;
    end else if (!counting_s) begin
      cnt <= '0;
    end else if (edge_s) begin
      cnt    <= '0;
      period <= meas_s;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= cnt;
    end
  end

  // State, run length and registered status outputs.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      good_cnt    <= '0;
      edge_tick   <= 1'b0;
      locked      <= 1'b0;
      fault       <= 1'b0;
      fault_count <= '0;
    end else begin
      state_r   <= state_nxt_s;
      good_cnt  <= good_cnt_nxt_s;
      edge_tick <= edge_s;
      locked    <= (state_nxt_s == LOCKED);
      fault     <= (state_nxt_s == FAULT);
      if ((state_nxt_s == FAULT) && (state_r != FAULT)) begin
        fault_count <= fault_cnt_inc(fault_count);
      end else begin
        fault_count <= fault_count;
      end
    end
  end

endmodule
